// File: rtl/regfile_if.sv
// Bus between the core (decode/write-back) and the register file: two
// combinational read ports, one write port, debug read and write-tracking outputs.
interface regfile_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [NUM_REGS-1:0] wr_mask;
    logic [15:0]       wr_count;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_mask, wr_count
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_mask, wr_count
    );
endinterface

// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file with same-cycle write-to-read bypass,
// hardwired-zero register 0, a registered debug port and write tracking.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic        clk,
    input logic        rst,
    regfile_if.slave   bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_mask_p1;
    logic [15:0]         wr_count_p1;
    logic [DATA_W-1:0]   dbg_data_p1;
    logic                commit;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Priority: reset, enable, address 0, bypass of this cycle's write, stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_ok,
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic              wen,
        input logic [ADDR_W-1:0] wad,
        input logic [DATA_W-1:0] wdat,
        input logic [DATA_W-1:0] stored
    );
        if (!rst_ok || !en || addr == '0)
            return '0;
        else if (wen && wad == addr)
            return wdat;
        else
            return stored;
    endfunction

    assign commit = bus.we && (bus.waddr != '0);

    // Stage p0 -> p1: storage, tracking and debug capture on the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_mask_p1  <= '0;
            wr_count_p1 <= '0;
            dbg_data_p1 <= '0;
        end else begin
            if (commit) begin
                regs[bus.waddr]       <= bus.wdata;
                wr_mask_p1[bus.waddr] <= 1'b1;
                wr_count_p1           <= sat_inc(wr_count_p1);
            end
            dbg_data_p1 <= (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];
        end
    end

    assign bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                                  bus.wdata, regs[bus.raddr1]);
    assign bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                                  bus.wdata, regs[bus.raddr2]);
    assign bus.dbg_data = dbg_data_p1;
    assign bus.wr_mask  = wr_mask_p1;
    assign bus.wr_count = wr_count_p1;

endmodule
